// File: rtl/csa_carry_resolver.sv
`default_nettype none
// ============================================================================
// Module      : csa_carry_resolver
// Description : Resolves a carry-save (S, Cout) pair into a binary sum, one
//               CHUNK_W-bit ripple slice per cycle, with valid/ready on both
//               sides.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_carry_resolver #(
    parameter int S_WIDTH = 22,
    parameter int C_WIDTH = 23,
    parameter int CHUNK_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [S_WIDTH:1]     S,
    input  logic [C_WIDTH:1]     Cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [S_WIDTH+2:1]   sum
);

    localparam int c_OUT_W  = S_WIDTH + 2;
    localparam int c_NCHUNK = (c_OUT_W + CHUNK_W - 1) / CHUNK_W;
    localparam int c_CNT_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NCHUNK - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADD  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_carry;
    logic [c_OUT_W-1:0]  r_ops;
    logic [c_OUT_W-1:0]  r_opc;
    logic [c_OUT_W-1:0]  r_sum;
    logic [c_OUT_W-1:0]  w_sum_nxt;
    logic [CHUNK_W:0]    w_res;
    logic                w_accept;
    logic                w_add;
    logic                w_last;

    assign w_accept = in_valid && (r_state == c_IDLE);
    assign w_add    = (r_state == c_ADD);
    assign w_last   = w_add && (r_cnt == c_LAST);

    // Operands shift down each cycle, so the active chunk is always at bit 0.
    assign w_res = {1'b0, r_ops[CHUNK_W-1:0]}
                 + {1'b0, r_opc[CHUNK_W-1:0]}
                 + {{CHUNK_W{1'b0}}, r_carry};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_state_nxt = c_ADD;
            c_ADD:   if (w_last)    w_state_nxt = c_DONE;
            c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    // Only bits of the chunk being resolved are written; others keep their value.
    for (genvar i = 0; i < c_OUT_W; i++) begin : g_bit
        localparam int c_CI = i / CHUNK_W;
        localparam int c_CJ = i % CHUNK_W;
        assign w_sum_nxt[i] = (w_add && (r_cnt == c_CNT_W'(c_CI))) ? w_res[c_CJ] : r_sum[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_ops   <= '0;
            r_opc   <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            if (w_accept) begin
                r_ops   <= {{(c_OUT_W-S_WIDTH){1'b0}}, S};
                r_opc   <= {{(c_OUT_W-C_WIDTH){1'b0}}, Cout};
                r_carry <= 1'b0;
                r_cnt   <= '0;
            end else if (w_add) begin
                r_ops   <= r_ops >> CHUNK_W;
                r_opc   <= r_opc >> CHUNK_W;
                r_carry <= w_res[CHUNK_W];
                r_cnt   <= w_last ? '0 : r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign sum       = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_csa_carry_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_carry_resolver
// Description : Self-checking bench for csa_carry_resolver at CHUNK_W=8 and 5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_carry_resolver;

    localparam int c_S_W = 22;
    localparam int c_C_W = 23;
    localparam int c_O_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [c_S_W:1]    S;
    logic [c_C_W:1]    Cout;
    logic              sel;

    logic              in_ready8, out_valid8, in_ready5, out_valid5;
    logic [c_O_W:1]    sum8, sum5;
    logic              ir, ov;
    logic [c_O_W:1]    sm;

    int checks = 0;
    int errors = 0;

    csa_carry_resolver #(.S_WIDTH(22), .C_WIDTH(23), .CHUNK_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .S(S), .Cout(Cout), .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8));

    csa_carry_resolver #(.S_WIDTH(22), .C_WIDTH(23), .CHUNK_W(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .S(S), .Cout(Cout), .out_valid(out_valid5), .out_ready(out_ready), .sum(sum5));

    assign ir = sel ? in_ready5  : in_ready8;
    assign ov = sel ? out_valid5 : out_valid8;
    assign sm = sel ? sum5       : sum8;

    always #5 clk = ~clk;

    // Reference: plain unsigned addition modulo 2^24.
    function automatic logic [c_O_W:1] model(input logic [c_S_W:1] s, input logic [c_C_W:1] c);
        return {2'b00, s} + {1'b0, c};
    endfunction

    function automatic int nchunk();
        int cw;
        cw = sel ? 5 : 8;
        return (c_O_W + cw - 1) / cw;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [c_S_W:1] s, input logic [c_C_W:1] c, input string name);
        int n;
        int lat;
        logic [c_O_W:1] e;
        e = model(s, c);
        S = s; Cout = c; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!ir && n < 20) begin tick(); n++; end
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got=%b want=1", name, ir);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!ov && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat != nchunk()) begin
            errors++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, nchunk());
        end
        checks++;
        if (sm !== e) begin
            errors++;
            $display("FAIL %s_sum got=%h want=%h", name, sm, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL %s_release got ov=%b ir=%b want ov=0 ir=1", name, ov, ir);
        end
    endtask

    task automatic test_reset();
        run_txn(22'h000003, 23'h000004, "pre_reset");
        in_valid = 1'b1; S = 22'h00002A; Cout = 23'h000011;
        rst = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (ov !== 1'b0 || sm !== 24'h000000 || ir !== 1'b1) begin
            errors++;
            $display("FAIL reset got ov=%b sum=%h ir=%b want ov=0 sum=000000 ir=1", ov, sm, ir);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_valid_ignored got ov=%b ir=%b want ov=0 ir=1", ov, ir);
        end
    endtask

    task automatic test_max();
        run_txn(22'h3FFFFF, 23'h7FFFFE, "max");
        checks++;
        if (model(22'h3FFFFF, 23'h7FFFFE) !== 24'hBFFFFD || sm !== 24'hBFFFFD) begin
            errors++;
            $display("FAIL max_const got=%h want=bffffd", sm);
        end
    endtask

    task automatic test_carry_chain();
        run_txn(22'h0000FF, 23'h000001, "carry1");
        run_txn(22'h00FFFF, 23'h000001, "carry2");
        run_txn(22'h3FFFFF, 23'h000001, "carry_all");
    endtask

    task automatic test_random();
        logic [c_S_W:1] s;
        logic [c_C_W:1] c;
        for (int k = 0; k < 12; k++) begin
            s = c_S_W'($urandom);
            c = c_C_W'($urandom);
            if (k == 0) s = '1;
            if (k == 1) c = '1;
            run_txn(s, c, "random");
        end
    endtask

    task automatic test_backpressure();
        int n;
        S = 22'd1; Cout = 23'd2; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!ir && n < 20) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ov && n < 20) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin in_valid = 1'b1; S = 22'd5; Cout = 23'd0; end
            if (k == 2) in_valid = 1'b0;
            checks++;
            if (ov !== 1'b1 || sm !== 24'h000003 || ir !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold got ov=%b sum=%h ir=%b want ov=1 sum=000003 ir=0", ov, sm, ir);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got ir=%b ov=%b want ir=1 ov=0", ir, ov);
        end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_no_capture got ov=%b ir=%b want ov=0 ir=1", ov, ir);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        S = 22'h3FFFFF; Cout = 23'h000001; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ov !== 1'b0 || sm !== 24'h000000) begin
            errors++;
            $display("FAIL reset_mid_add got ov=%b sum=%h want ov=0 sum=000000", ov, sm);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (ov) seen++; end
        out_ready = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_add_no_output got=%0d want=0", seen);
        end
        // Abort while holding a result in DONE.
        S = 22'h1234AB; Cout = 23'h00F00F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < nchunk(); k++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ov !== 1'b0 || sm !== 24'h000000 || ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_done got ov=%b sum=%h ir=%b want ov=0 sum=000000 ir=1", ov, sm, ir);
        end
        tick();
        rst = 1'b0;
        tick();
        run_txn(22'd10, 23'd20, "after_reset");
    endtask

    task automatic test_back_to_back();
        int acc;
        int nout;
        int t_out[4];
        logic [c_O_W:1] v_out[4];
        logic prev_ir;
        acc = 0; nout = 0;
        S = 22'd1; Cout = 23'd2; in_valid = 1'b1; out_ready = 1'b1;
        prev_ir = ir;
        for (int cyc = 1; cyc < 60 && nout < 4; cyc++) begin
            tick();
            if (prev_ir && in_valid) acc++;
            if (ov) begin t_out[nout] = cyc; v_out[nout] = sm; nout++; end
            if (ir) begin
                if (acc < 4) begin
                    S = c_S_W'(acc + 1);
                    Cout = c_C_W'(2 * (acc + 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            prev_ir = ir;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nout != 4) begin
            errors++;
            $display("FAIL stream_count got=%0d want=4", nout);
        end
        for (int k = 0; k < nout; k++) begin
            checks++;
            if (v_out[k] !== c_O_W'(3 * (k + 1))) begin
                errors++;
                $display("FAIL stream_sum[%0d] got=%h want=%h", k, v_out[k], c_O_W'(3 * (k + 1)));
            end
            if (k > 0) begin
                checks++;
                if (t_out[k] - t_out[k-1] != nchunk() + 2) begin
                    errors++;
                    $display("FAIL stream_interval[%0d] got=%0d want=%0d", k, t_out[k] - t_out[k-1], nchunk() + 2);
                end
            end
        end
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        S = '0; Cout = '0;
        tick(); tick();
        checks++;
        if (sm !== 24'h000000 || ov !== 1'b0) begin
            errors++;
            $display("FAIL power_on got sum=%h ov=%b want sum=000000 ov=0", sm, ov);
        end
        rst = 1'b0;
        tick();
        test_reset();
        test_max();
        test_carry_chain();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        // Same scenarios on the CHUNK_W=5 instance (narrow last chunk).
        rst = 1'b1; tick(); rst = 1'b0; sel = 1'b1; tick();
        test_max();
        test_carry_chain();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa_carry_resolver.md
# csa_carry_resolver

Multi-cycle carry-propagate stage that converts a carry-save pair (sum vector S and carry vector Cout, as produced by the 3:2 CSA compressors) into a single binary result. It sits at the output of the CSA reduction tree in the MGEMMV datapath. It resolves the redundant form a chunk at a time, with one CHUNK_W-bit ripple slice per cycle, so the accumulator does not need a full-width adder. Upstream and downstream both use valid/ready handshakes.

## Interface
- S_WIDTH, default 22: width of the sum vector S.
- C_WIDTH, default 23: width of the carry vector Cout; must equal S_WIDTH+1.
- CHUNK_W, default 8: bits resolved per cycle; 1 ≤ CHUNK_W ≤ OUT_W.
- Derived OUT_W = S_WIDTH+2 (24): result width.
- Derived NCHUNK = ceil(OUT_W/CHUNK_W) (3 at defaults).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  S/Cout pair is valid.
- in_ready  out  1  block can accept a pair; high only in IDLE.
- S  in  [S_WIDTH:1]  carry-save sum vector; bit 1 is the LSB.
- Cout  in  [C_WIDTH:1]  carry-save carry vector, already weight-aligned; bit 1 is the LSB.
- out_valid  out  1  sum holds a resolved result.
- out_ready  in  1  consumer accepts the result.
- sum  out  [OUT_W:1]  binary result S + Cout.

## Operation
- State machine has three states: IDLE, ADD, DONE.
- **IDLE**
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready, capture S and Cout zero-extended to OUT_W into operand registers.
  - Clear the carry register and the chunk counter cnt, then go to ADD.
- **ADD**
  - in_ready=0 and out_valid=0.
  - Each cycle: chunk cnt = opS[chunk] + opC[chunk] + carry.
  - Write the low CHUNK_W bits into sum chunk cnt, write the chunk carry-out into the carry register, then cnt++.
  - The chunk occupies bits cnt*CHUNK_W+1 through min((cnt+1)*CHUNK_W, OUT_W).
  - The last chunk may be narrower than CHUNK_W. Its carry-out is discarded; it is provably 0, since (2^S_WIDTH−1)+(2^C_WIDTH−1) < 2^OUT_W.
  - When the chunk with cnt=NCHUNK−1 completes, go to DONE.
- **DONE**
  - out_valid=1; sum is stable.
  - On out_ready=1, go to IDLE.
  - in_valid is ignored in ADD and DONE; there is no overlap and no input buffering.
- Cout[1] is added as given; it is not forced to zero.
- The arithmetic is unsigned modulo 2^OUT_W; there is no overflow flag.
- sum bits of chunks not yet written hold their previous value. Consumers must sample only while out_valid=1.

## Timing
- **Reset values**
  - State IDLE, cnt=0, carry=0.
  - Operand registers and sum = 0; out_valid=0.
  - in_ready=1 once rst deasserts.
- **Latency**
  - Accept at edge E0.
  - Chunks are resolved at edges E1..E_NCHUNK.
  - out_valid rises after E_NCHUNK, i.e. NCHUNK cycles after acceptance (3 at defaults).
- **Output handshake**
  - The result is consumed at the first edge after E_NCHUNK at which out_valid&out_ready.
  - in_ready is high in the following cycle.
- **Throughput**
  - With in_valid and out_ready held high, one result every NCHUNK+2 cycles (5 at defaults).
- **Backpressure**: with out_ready low, the block stays in DONE indefinitely. sum and out_valid must not change and in_ready stays 0.
- **Reset mid-operation**: asserting rst in ADD or DONE immediately aborts the transaction and returns every register to its reset value. There is no partial output.
- **Reset and handshakes**: a handshake coincident with an rst assertion is lost. Neither side may consider it completed.
- **in_valid during rst**: in_valid asserted while rst is high has no effect.

## Test plan
- **Reset**: assert rst mid-idle → out_valid=0, sum=24'h000000, in_ready=1 after release.
- **Maximum operands**: S=22'h3FFFFF, Cout=23'h7FFFFE, out_ready=1 → out_valid exactly 3 cycles after accept, sum=24'hBFFFFD.
- **Inter-chunk carry**: S=22'h0000FF, Cout=23'h000001 → sum=24'h000100. Then S=22'h00FFFF, Cout=23'h000001 → sum=24'h010000, carry crosses two chunk boundaries.
- **Backpressure**: result 24'h000003 (S=1, Cout=2) with out_ready low for 5 cycles → sum and out_valid held constant, in_ready=0. A second in_valid pulse with S=5 is not captured. Raising out_ready completes the transfer, and in_ready=1 the next cycle.
- **Reset mid-ADD**: pulse rst after one chunk edge of S=22'h3FFFFF, Cout=23'h000001 → out_valid never asserts and sum=0. The next transaction, S=10, Cout=20, yields sum=30.
- **Streaming**: in_valid and out_ready held high for 4 transactions (S=i, Cout=2i, i=1..4) → out_valid pulses one cycle every 5 cycles with sums 3, 6, 9, 12. At CHUNK_W=5 (NCHUNK=5, last chunk 4 bits) the same sequence must give identical sums with latency 5.
